pooling_top_core: RTL and testbench

Per-lane 2×2 stride-2 max-pooling engine that sits on the output of the 32-column systolic array. Each column drives a raster-ordered IMG_H×IMG_W feature map, one sample per enabled cycle. Each lane emits the IMG_H/2×IMG_W/2 pooled map, also in raster order. Lanes are fully independent and may start at different cycles.

---
 rtl/pooling_pkg.sv | 28 ++
 rtl/pooling_lane.sv | 98 +++++++++
 rtl/pooling_top_core.sv | 29 ++
 tb/tb_pooling_top_core.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
// rtl/pooling_pkg.sv - shared sizes and max helper for the 2x2 max-pooling engine
// POOLING_SIGNED_EN selects signed max comparisons; otherwise comparisons are unsigned.
package pooling_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int COL        = 32;
  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;

  localparam int OUT_W = IMG_W / 2;
  localparam int OUT_H = IMG_H / 2;
  localparam int OUT_N = OUT_W * OUT_H;

  localparam int COL_CW = $clog2(IMG_W);
  localparam int ROW_CW = $clog2(IMG_H);
  localparam int OUT_CW = $clog2(OUT_N);
  localparam int LB_AW  = $clog2(OUT_W);

  function automatic logic [DATA_WIDTH-1:0] pool_max(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
`ifdef POOLING_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

endpackage

// File: rtl/pooling_lane.sv
// rtl/pooling_lane.sv - one raster-order 2x2 stride-2 max-pooling lane
// Comparison signedness follows POOLING_SIGNED_EN through pooling_pkg::pool_max.
module pooling_lane
  import pooling_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [DATA_WIDTH-1:0] pool_out,
  output logic                  pool_done,
  output logic                  pool_finish
);

  logic [COL_CW-1:0]     col_q, col_d;
  logic [ROW_CW-1:0]     row_q, row_d;
  logic [OUT_CW-1:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic [DATA_WIDTH-1:0] line_buf_q [OUT_W];
  logic [DATA_WIDTH-1:0] line_buf_d [OUT_W];
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  done_q, done_d;
  logic                  finish_q, finish_d;
  logic [LB_AW-1:0]      lb_idx;

  assign lb_idx = LB_AW'(col_q >> 1);

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    pair_d     = pair_q;
    line_buf_d = line_buf_q;
    out_d      = out_q;
    done_d     = 1'b0;
    finish_d   = finish_q;

    if (!start) begin
      // pooling_out deliberately keeps its last result across a stop
      col_d    = '0;
      row_d    = '0;
      cnt_d    = '0;
      pair_d   = '0;
      finish_d = 1'b0;
      for (int i = 0; i < OUT_W; i++) line_buf_d[i] = '0;
    end else if (en) begin
      if (!col_q[0]) begin
        pair_d = sample;
      end else if (!row_q[0]) begin
        line_buf_d[lb_idx] = pool_max(pair_q, sample);
      end else begin
        out_d  = pool_max(line_buf_q[lb_idx], pool_max(pair_q, sample));
        done_d = 1'b1;
        if (cnt_q == OUT_CW'(OUT_N - 1)) begin
          cnt_d    = '0;
          finish_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      if (col_q == COL_CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_CW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      col_q    <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
      pair_q   <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
      finish_q <= 1'b0;
      for (int i = 0; i < OUT_W; i++) line_buf_q[i] <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      pair_q     <= pair_d;
      out_q      <= out_d;
      done_q     <= done_d;
      finish_q   <= finish_d;
      line_buf_q <= line_buf_d;
    end
  end

  assign pool_out    = out_q;
  assign pool_done   = done_q;
  assign pool_finish = finish_q;

endmodule

// File: rtl/pooling_top_core.sv
// rtl/pooling_top_core.sv - COL independent max-pooling lanes behind the systolic array
// Build with POOLING_SIGNED_EN defined for signed max comparisons.
module pooling_top_core
  import pooling_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  en             [COL],
  input  logic [DATA_WIDTH-1:0] sys_out        [COL],
  output logic [DATA_WIDTH-1:0] pooling_out    [COL],
  output logic                  pooling_done   [COL],
  output logic                  pooling_finish [COL]
);

  for (genvar g = 0; g < COL; g++) begin : g_lane
    pooling_lane u_lane (
      .clk        (clk),
      .nrst       (nrst),
      .start      (start),
      .en         (en[g]),
      .sample     (sys_out[g]),
      .pool_out   (pooling_out[g]),
      .pool_done  (pooling_done[g]),
      .pool_finish(pooling_finish[g])
    );
  end

endmodule

// File: tb/tb_pooling_top_core.sv
// tb/tb_pooling_top_core.sv - directed self-checking bench for pooling_top_core
// Expected values follow POOLING_SIGNED_EN when the bench is built with it.
module tb_pooling_top_core;
  import pooling_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int NGOT = 2 * OUT_N;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic                  start;
  logic                  en             [COL];
  logic [DATA_WIDTH-1:0] sys_out        [COL];
  logic [DATA_WIDTH-1:0] pooling_out    [COL];
  logic                  pooling_done   [COL];
  logic                  pooling_finish [COL];

  always #5 clk = ~clk;

  pooling_top_core dut (
    .clk           (clk),
    .nrst          (nrst),
    .start         (start),
    .en            (en),
    .sys_out       (sys_out),
    .pooling_out   (pooling_out),
    .pooling_done  (pooling_done),
    .pooling_finish(pooling_finish)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_max(input logic [15:0] a, input logic [15:0] b);
`ifdef POOLING_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  logic [15:0] img [2][NPIX];
  logic [15:0] exp_val_q [2][$];
  int          exp_cyc_q [2][$];
  logic [15:0] got [2][NGOT];
  int          run_pulses [2];
  int          clr_pulses [2];
  int          stray = 0;
  int          cyc = 0;
  logic [15:0] ev;
  int          ec;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] win_max(input int l, input int q);
    return ref_max(ref_max(img[l][q-IMG_W-1], img[l][q-IMG_W]),
                   ref_max(img[l][q-1], img[l][q]));
  endfunction

  always @(negedge clk) begin
    for (int i = 2; i < COL; i++) if (pooling_done[i]) stray++;
    for (int l = 0; l < 2; l++) begin
      if (pooling_done[l]) begin
        if (exp_val_q[l].size() == 0) begin
          check_val($sformatf("lane%0d_unexp_pulse", l), 32'(pooling_done[l]), 32'd0);
        end else begin
          ev = exp_val_q[l].pop_front();
          ec = exp_cyc_q[l].pop_front();
          clr_pulses[l]++;
          check_val($sformatf("lane%0d_val_%0d", l, run_pulses[l]), 32'(pooling_out[l]), 32'(ev));
          check_val($sformatf("lane%0d_cyc_%0d", l, run_pulses[l]), cyc, ec);
          check_val($sformatf("lane%0d_finish_%0d", l, run_pulses[l]),
                    32'(pooling_finish[l]), 32'(clr_pulses[l] >= OUT_N));
        end
        if (run_pulses[l] < NGOT) got[l][run_pulses[l]] = pooling_out[l];
        run_pulses[l]++;
      end
    end
  end

  task automatic run_lanes(input int npix0, input int npix1, input int dly1, input int stall);
    int p [2];
    int n, dly, q, t;
    p[0] = 0; p[1] = 0; t = 0;
    run_pulses[0] = 0; run_pulses[1] = 0;
    while ((p[0] < npix0 || p[1] < npix1) && t < 20000) begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        n   = (l == 0) ? npix0 : npix1;
        dly = (l == 0) ? 0 : dly1;
        if (t >= dly && p[l] < n && !(stall > 0 && (t % stall) == stall - 1)) begin
          q = p[l] % NPIX;
          en[l] = 1'b1;
          sys_out[l] = img[l][q];
          if (((q / IMG_W) % 2 == 1) && ((q % IMG_W) % 2 == 1)) begin
            exp_val_q[l].push_back(win_max(l, q));
            exp_cyc_q[l].push_back(cyc + 1);
          end
          p[l]++;
        end else begin
          en[l] = 1'b0;
          sys_out[l] = 16'($urandom);
        end
      end
      t++;
    end
    @(negedge clk);
    en[0] = 1'b0; en[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_val("lane0_pending", exp_val_q[0].size(), 0);
    check_val("lane1_pending", exp_val_q[1].size(), 0);
  endtask

  task automatic stop_lanes();
    @(negedge clk);
    start = 1'b0;
    clr_pulses[0] = 0; clr_pulses[1] = 0;
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NPIX; i++) img[1][i] = 16'(i);
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < COL; i++) begin
      en[i] = 1'b0;
      sys_out[i] = '0;
    end
    clr_pulses[0] = 0; clr_pulses[1] = 0;
    run_pulses[0] = 0; run_pulses[1] = 0;
    repeat (2) @(negedge clk);
    check_val("rst_out1", 32'(pooling_out[1]), 0);
    check_val("rst_out31", 32'(pooling_out[31]), 0);
    check_val("rst_done1", 32'(pooling_done[1]), 0);
    check_val("rst_finish1", 32'(pooling_finish[1]), 0);
    nrst = 1'b1;
    start = 1'b1;

    // lane 1 ramp, lane 0 random data two cycles ahead of it
    load_ramp();
    for (int i = 0; i < NPIX; i++) img[0][i] = 16'($urandom);
    run_lanes(NPIX, NPIX, 2, 0);
    check_val("ramp_pulses", run_pulses[1], OUT_N);
    check_val("rand_pulses", run_pulses[0], OUT_N);
    check_val("ramp_first", 32'(got[1][0]), 29);
    check_val("ramp_second", 32'(got[1][1]), 31);
    check_val("ramp_15th", 32'(got[1][14]), 85);
    check_val("ramp_last", 32'(got[1][OUT_N-1]), 783);
    check_val("ramp_finish", 32'(pooling_finish[1]), 1);
    stop_lanes();
    check_val("stop_out_hold", 32'(pooling_out[1]), 783);
    check_val("stop_finish_clr", 32'(pooling_finish[1]), 0);

    run_lanes(0, NPIX, 0, 3);
    check_val("stall_pulses", run_pulses[1], OUT_N);
    check_val("stall_first", 32'(got[1][0]), 29);
    check_val("stall_last", 32'(got[1][OUT_N-1]), 783);
    stop_lanes();

    for (int i = 0; i < NPIX; i++) img[1][i] = '0;
    img[1][0] = 16'hFFFB; img[1][1] = 16'hFFFE;
    img[1][IMG_W] = 16'hFFF7; img[1][IMG_W+1] = 16'hFFFD;
    img[1][2] = 16'h0001; img[1][3] = 16'hFFFF;
    run_lanes(0, 2 * IMG_W, 0, 0);
    check_val("win_pulses", run_pulses[1], OUT_W);
    check_val("win_neg", 32'(got[1][0]), 32'hFFFE);
`ifdef POOLING_SIGNED_EN
    check_val("win_sign", 32'(got[1][1]), 32'h0001);
`else
    check_val("win_sign", 32'(got[1][1]), 32'hFFFF);
`endif
    stop_lanes();

    load_ramp();
    run_lanes(0, 300, 0, 0);
    @(negedge clk);
    nrst = 1'b0;
    clr_pulses[1] = 0;
    @(negedge clk);
    check_val("mid_rst_out", 32'(pooling_out[1]), 0);
    check_val("mid_rst_done", 32'(pooling_done[1]), 0);
    check_val("mid_rst_finish", 32'(pooling_finish[1]), 0);
    nrst = 1'b1;
    run_lanes(0, NPIX, 0, 0);
    check_val("post_rst_pulses", run_pulses[1], OUT_N);
    check_val("post_rst_first", 32'(got[1][0]), 29);
    stop_lanes();

    run_lanes(0, 2 * NPIX, 0, 0);
    check_val("b2b_pulses", run_pulses[1], 2 * OUT_N);
    check_val("b2b_second_first", 32'(got[1][OUT_N]), 29);
    check_val("b2b_last", 32'(got[1][2*OUT_N-1]), 783);
    check_val("b2b_finish", 32'(pooling_finish[1]), 1);

    check_val("stray_pulses", stray, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
